// File: rtl/arm_pipeline_pkg.sv
// Shared types for the instruction/data memory arbiter.
package arm_pipeline_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_IFETCH = 2'd1,
    ARB_DATA   = 2'd2
  } arb_state_t;

  typedef enum logic {
    ARB_REQ_I = 1'b0,
    ARB_REQ_D = 1'b1
  } arb_req_t;

endpackage

// File: rtl/arm_arb_pick.sv
// Grant selection between fetch and data requesters.
// ARM_ARB_ROUND_ROBIN_EN: on a tie, grant the requester not served last; otherwise data wins.
module arm_arb_pick
  import arm_pipeline_pkg::*;
(
  input  logic     i_IReq,
  input  logic     i_DReq,
  input  arb_req_t i_LastGrant,
  output arb_req_t o_Grant
);

`ifndef ARM_ARB_ROUND_ROBIN_EN
  logic w_unused_last;
  assign w_unused_last = (i_LastGrant == ARB_REQ_D);
`endif

  always_comb begin
    o_Grant = ARB_REQ_D;
    if (i_IReq && i_DReq) begin
`ifdef ARM_ARB_ROUND_ROBIN_EN
      o_Grant = (i_LastGrant == ARB_REQ_D) ? ARB_REQ_I : ARB_REQ_D;
`else
      o_Grant = ARB_REQ_D;
`endif
    end else if (i_IReq) begin
      o_Grant = ARB_REQ_I;
    end
  end

endmodule

// File: rtl/arm_mem_arbiter.sv
// Single-port memory arbiter serving instruction fetch and data requesters.
// ARM_ARB_ROUND_ROBIN_EN enables round-robin tie-break (last-grant register).
//   state      | meaning
//   ARB_IDLE   | no transaction, sampling requests
//   ARB_IFETCH | fetch read on memory port
//   ARB_DATA   | data load/store on memory port
module arm_mem_arbiter
  import arm_pipeline_pkg::*;
#(
  parameter int BusWidth = 32
) (
  input  logic                i_CLK,
  input  logic                i_NRESET,
  input  logic                i_SCLR,
  input  logic                i_IReq,
  input  logic [BusWidth-1:0] i_IAddr,
  output logic                o_IValid,
  output logic [BusWidth-1:0] o_IRData,
  input  logic                i_DReq,
  input  logic                i_DWe,
  input  logic [BusWidth-1:0] i_DAddr,
  input  logic [BusWidth-1:0] i_DWData,
  output logic                o_DValid,
  output logic [BusWidth-1:0] o_DRData,
  output logic                o_MReq,
  output logic                o_MWe,
  output logic [BusWidth-1:0] o_MAddr,
  output logic [BusWidth-1:0] o_MWData,
  input  logic                i_MReady,
  input  logic [BusWidth-1:0] i_MRData,
  output logic                o_Stall_Fetch,
  output logic                o_Stall_Memory
);

  arb_state_t          r_state;
  arb_state_t          w_next_state;
  logic [BusWidth-1:0] r_addr;
  logic [BusWidth-1:0] r_wdata;
  logic                r_we;
  logic                r_ivalid;
  logic                r_dvalid;
  logic [BusWidth-1:0] r_irdata;
  logic [BusWidth-1:0] r_drdata;
  logic                r_sclr_pend;
  arb_req_t            w_last;
  arb_req_t            w_grant;
  arb_req_t            w_start_sel;
  logic                w_start;
  logic                w_complete;
  logic                w_abort;
  logic                w_ireq_eff;
  logic                w_dreq_eff;

  // A requester is not eligible in the cycle its completion pulse is visible.
  assign w_ireq_eff = i_IReq & ~r_ivalid;
  assign w_dreq_eff = i_DReq & ~r_dvalid;
  assign w_abort    = i_SCLR | r_sclr_pend;

`ifdef ARM_ARB_ROUND_ROBIN_EN
  arb_req_t r_last;
  assign w_last = r_last;
`else
  assign w_last = ARB_REQ_I;
`endif

  arm_arb_pick u_pick (
    .i_IReq      (w_ireq_eff),
    .i_DReq      (w_dreq_eff),
    .i_LastGrant (w_last),
    .o_Grant     (w_grant)
  );

  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_start_sel  = w_grant;
    w_complete   = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (!i_SCLR && (w_ireq_eff || w_dreq_eff)) begin
          w_start      = 1'b1;
          w_next_state = (w_grant == ARB_REQ_D) ? ARB_DATA : ARB_IFETCH;
        end
      end
      ARB_IFETCH: begin
        if (i_MReady) begin
          w_complete   = 1'b1;
          w_next_state = ARB_IDLE;
          if (!w_abort && w_dreq_eff) begin
            w_start      = 1'b1;
            w_start_sel  = ARB_REQ_D;
            w_next_state = ARB_DATA;
          end
        end
      end
      ARB_DATA: begin
        if (i_MReady) begin
          w_complete   = 1'b1;
          w_next_state = ARB_IDLE;
          if (!w_abort && w_ireq_eff) begin
            w_start      = 1'b1;
            w_start_sel  = ARB_REQ_I;
            w_next_state = ARB_IFETCH;
          end
        end
      end
      default: w_next_state = ARB_IDLE;
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_NRESET) begin
    if (!i_NRESET) begin
      r_state     <= ARB_IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_we        <= 1'b0;
      r_ivalid    <= 1'b0;
      r_dvalid    <= 1'b0;
      r_irdata    <= '0;
      r_drdata    <= '0;
      r_sclr_pend <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_ivalid <= w_complete && !w_abort && (r_state == ARB_IFETCH);
      r_dvalid <= w_complete && !w_abort && (r_state == ARB_DATA);
      if (w_complete && !w_abort) begin
        if (r_state == ARB_IFETCH) begin
          r_irdata <= i_MRData;
        end else if (!r_we) begin
          r_drdata <= i_MRData;
        end
      end
      // A clear seen mid-transaction must survive until memory completes.
      if (w_complete) begin
        r_sclr_pend <= 1'b0;
      end else if (i_SCLR && (r_state != ARB_IDLE)) begin
        r_sclr_pend <= 1'b1;
      end
      if (w_start) begin
        if (w_start_sel == ARB_REQ_D) begin
          r_addr  <= i_DAddr;
          r_wdata <= i_DWData;
          r_we    <= i_DWe;
        end else begin
          r_addr  <= i_IAddr;
          r_wdata <= '0;
          r_we    <= 1'b0;
        end
      end
    end
  end

`ifdef ARM_ARB_ROUND_ROBIN_EN
  always_ff @(posedge i_CLK or negedge i_NRESET) begin
    if (!i_NRESET) begin
      r_last <= ARB_REQ_I;
    end else if (w_start) begin
      r_last <= w_start_sel;
    end
  end
`endif

  assign o_MReq         = (r_state != ARB_IDLE);
  assign o_MAddr        = r_addr;
  assign o_MWData       = r_wdata;
  assign o_MWe          = r_we;
  assign o_IValid       = r_ivalid;
  assign o_DValid       = r_dvalid;
  assign o_IRData       = r_irdata;
  assign o_DRData       = r_drdata;
  assign o_Stall_Fetch  = i_NRESET & i_IReq & ~r_ivalid;
  assign o_Stall_Memory = i_NRESET & i_DReq & ~r_dvalid;

endmodule

// File: tb/tb_arm_mem_arbiter.sv
// Bench for arm_mem_arbiter: directed scenarios then random traffic against a transaction model.
module tb_arm_mem_arbiter;

  logic        i_CLK = 1'b0;
  logic        i_NRESET = 1'b0;
  logic        i_SCLR = 1'b0;
  logic        i_IReq = 1'b0;
  logic [31:0] i_IAddr = '0;
  logic        o_IValid;
  logic [31:0] o_IRData;
  logic        i_DReq = 1'b0;
  logic        i_DWe = 1'b0;
  logic [31:0] i_DAddr = '0;
  logic [31:0] i_DWData = '0;
  logic        o_DValid;
  logic [31:0] o_DRData;
  logic        o_MReq;
  logic        o_MWe;
  logic [31:0] o_MAddr;
  logic [31:0] o_MWData;
  logic        i_MReady = 1'b0;
  logic [31:0] i_MRData = '0;
  logic        o_Stall_Fetch;
  logic        o_Stall_Memory;

`ifdef ARM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  localparam int SRC_NONE = 0;
  localparam int SRC_I    = 1;
  localparam int SRC_D    = 2;

  int n_checks = 0;
  int n_errors = 0;

  arm_mem_arbiter #(.BusWidth(32)) dut (
    .i_CLK          (i_CLK),
    .i_NRESET       (i_NRESET),
    .i_SCLR         (i_SCLR),
    .i_IReq         (i_IReq),
    .i_IAddr        (i_IAddr),
    .o_IValid       (o_IValid),
    .o_IRData       (o_IRData),
    .i_DReq         (i_DReq),
    .i_DWe          (i_DWe),
    .i_DAddr        (i_DAddr),
    .i_DWData       (i_DWData),
    .o_DValid       (o_DValid),
    .o_DRData       (o_DRData),
    .o_MReq         (o_MReq),
    .o_MWe          (o_MWe),
    .o_MAddr        (o_MAddr),
    .o_MWData       (o_MWData),
    .i_MReady       (i_MReady),
    .i_MRData       (i_MRData),
    .o_Stall_Fetch  (o_Stall_Fetch),
    .o_Stall_Memory (o_Stall_Memory)
  );

  always #5 i_CLK = ~i_CLK;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_CLK);
    @(negedge i_CLK);
  endtask

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5AA5A5;
  endfunction

  int          last_served;
  logic [31:0] last_dread;

  initial begin
    // reset
    i_IReq = 1'b1;
    @(negedge i_CLK);
    @(negedge i_CLK);
    check_val("rst_mreq", {31'd0, o_MReq}, 32'd0);
    check_val("rst_ivalid", {31'd0, o_IValid}, 32'd0);
    check_val("rst_dvalid", {31'd0, o_DValid}, 32'd0);
    check_val("rst_maddr", o_MAddr, 32'd0);
    check_val("rst_irdata", o_IRData, 32'd0);
    check_val("rst_stallf", {31'd0, o_Stall_Fetch}, 32'd0);
    i_IReq = 1'b0;
    i_NRESET = 1'b1;
    step();

    // single fetch
    i_IReq = 1'b1; i_IAddr = 32'h100;
    step();
    check_val("f_mreq", {31'd0, o_MReq}, 32'd1);
    check_val("f_maddr", o_MAddr, 32'h100);
    check_val("f_mwe", {31'd0, o_MWe}, 32'd0);
    check_val("f_stall", {31'd0, o_Stall_Fetch}, 32'd1);
    i_MReady = 1'b1; i_MRData = 32'hE3A00001;
    step();
    check_val("f_ivalid", {31'd0, o_IValid}, 32'd1);
    check_val("f_irdata", o_IRData, 32'hE3A00001);
    check_val("f_stall_done", {31'd0, o_Stall_Fetch}, 32'd0);
    check_val("f_mreq_done", {31'd0, o_MReq}, 32'd0);
    i_IReq = 1'b0; i_MReady = 1'b0;
    step();
    check_val("f_ivalid_pulse", {31'd0, o_IValid}, 32'd0);

    // simultaneous: data first, fetch chained
    i_IReq = 1'b1; i_IAddr = 32'h104;
    i_DReq = 1'b1; i_DWe = 1'b0; i_DAddr = 32'h200;
    step();
    check_val("s_maddr_d", o_MAddr, 32'h200);
    check_val("s_stallf1", {31'd0, o_Stall_Fetch}, 32'd1);
    i_MReady = 1'b1; i_MRData = 32'h11112222;
    step();
    check_val("s_dvalid", {31'd0, o_DValid}, 32'd1);
    check_val("s_drdata", o_DRData, 32'h11112222);
    check_val("s_nobubble", {31'd0, o_MReq}, 32'd1);
    check_val("s_maddr_i", o_MAddr, 32'h104);
    check_val("s_stallf2", {31'd0, o_Stall_Fetch}, 32'd1);
    i_DReq = 1'b0; i_MRData = 32'h33334444;
    step();
    check_val("s_ivalid", {31'd0, o_IValid}, 32'd1);
    check_val("s_irdata", o_IRData, 32'h33334444);
    i_IReq = 1'b0; i_MReady = 1'b0;
    step();

    // store with three wait states
    i_DReq = 1'b1; i_DWe = 1'b1; i_DAddr = 32'h40; i_DWData = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) begin
      step();
      check_val("w_mreq", {31'd0, o_MReq}, 32'd1);
      check_val("w_mwe", {31'd0, o_MWe}, 32'd1);
      check_val("w_maddr", o_MAddr, 32'h40);
      check_val("w_mwdata", o_MWData, 32'hDEADBEEF);
      check_val("w_novalid", {31'd0, o_DValid}, 32'd0);
      if (i == 3) begin
        i_MReady = 1'b1; i_MRData = 32'h55555555;
      end
    end
    step();
    check_val("w_dvalid", {31'd0, o_DValid}, 32'd1);
    check_val("w_drdata_keep", o_DRData, 32'h11112222);
    i_DReq = 1'b0; i_DWe = 1'b0; i_MReady = 1'b0;
    step();

    // synchronous clear during data transaction
    i_DReq = 1'b1; i_DAddr = 32'h300;
    step();
    check_val("c_mreq0", {31'd0, o_MReq}, 32'd1);
    i_SCLR = 1'b1;
    step();
    i_SCLR = 1'b0; i_DReq = 1'b0;
    check_val("c_mreq1", {31'd0, o_MReq}, 32'd1);
    step();
    check_val("c_mreq2", {31'd0, o_MReq}, 32'd1);
    i_MReady = 1'b1; i_MRData = 32'h77777777;
    step();
    check_val("c_nodvalid", {31'd0, o_DValid}, 32'd0);
    check_val("c_idle", {31'd0, o_MReq}, 32'd0);
    check_val("c_drdata", o_DRData, 32'h11112222);
    i_MReady = 1'b0;
    step();
    check_val("c_nodvalid2", {31'd0, o_DValid}, 32'd0);

    // reset mid-fetch
    i_IReq = 1'b1; i_IAddr = 32'h700;
    step();
    check_val("r_mreq_pre", {31'd0, o_MReq}, 32'd1);
    i_NRESET = 1'b0;
    #1;
    check_val("r_mreq", {31'd0, o_MReq}, 32'd0);
    check_val("r_maddr", o_MAddr, 32'd0);
    check_val("r_irdata", o_IRData, 32'd0);
    check_val("r_drdata", o_DRData, 32'd0);
    check_val("r_stallf", {31'd0, o_Stall_Fetch}, 32'd0);
    i_MReady = 1'b1;
    step();
    i_NRESET = 1'b1; i_IReq = 1'b0;
    begin
      logic seen = 1'b0;
      for (int i = 0; i < 3; i++) begin
        step();
        seen = seen | o_IValid;
      end
      check_val("r_noivalid", {31'd0, seen}, 32'd0);
    end
    i_MReady = 1'b0;
    step();

    // repeated tie from idle: grant order
    last_served = SRC_I;
    last_dread  = 32'd0;
    for (int k = 0; k < 4; k++) begin
      int win;
      win = (RR && last_served == SRC_D) ? SRC_I : SRC_D;
      i_IReq = 1'b1; i_IAddr = 32'h500 + k * 4;
      i_DReq = 1'b1; i_DWe = 1'b0; i_DAddr = 32'h600 + k * 4;
      step();
      check_val("t_grant", o_MAddr, (win == SRC_D) ? i_DAddr : i_IAddr);
      if (win == SRC_D) i_IReq = 1'b0; else i_DReq = 1'b0;
      i_MReady = 1'b1; i_MRData = 32'hD0000000 + k;
      step();
      check_val("t_valid", {30'd0, o_DValid, o_IValid}, (win == SRC_D) ? 32'd2 : 32'd1);
      if (win == SRC_D) last_dread = 32'hD0000000 + k;
      last_served = win;
      i_IReq = 1'b0; i_DReq = 1'b0; i_MReady = 1'b0;
      step();
    end

    // random traffic against transaction model
    begin
      int   cur = SRC_NONE;
      int   nxt;
      int   n_done = 0;
      logic p_mreq = 1'b0, p_mrdy = 1'b0, p_ival = 1'b0, p_dval = 1'b0;
      logic p_ireq = 1'b0, p_dreq = 1'b0;
      logic eff_i, eff_d, exp_iv, exp_dv;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        step();
        eff_i  = p_ireq & ~p_ival;
        eff_d  = p_dreq & ~p_dval;
        exp_iv = 1'b0;
        exp_dv = 1'b0;
        nxt    = cur;
        if (!p_mreq) begin
          if (eff_i && eff_d) nxt = (RR && last_served == SRC_D) ? SRC_I : SRC_D;
          else if (eff_d)     nxt = SRC_D;
          else if (eff_i)     nxt = SRC_I;
          else                nxt = SRC_NONE;
        end else if (p_mrdy) begin
          exp_iv = (cur == SRC_I);
          exp_dv = (cur == SRC_D);
          if (cur == SRC_I) nxt = eff_d ? SRC_D : SRC_NONE;
          else              nxt = eff_i ? SRC_I : SRC_NONE;
        end
        if (nxt != SRC_NONE && (nxt != cur || exp_iv || exp_dv || !p_mreq)) last_served = nxt;
        cur = nxt;

        check_val("x_mreq", {31'd0, o_MReq}, {31'd0, cur != SRC_NONE});
        if (cur == SRC_I) begin
          check_val("x_maddr_i", o_MAddr, i_IAddr);
          check_val("x_mwe_i", {31'd0, o_MWe}, 32'd0);
        end else if (cur == SRC_D) begin
          check_val("x_maddr_d", o_MAddr, i_DAddr);
          check_val("x_mwe_d", {31'd0, o_MWe}, {31'd0, i_DWe});
          if (i_DWe) check_val("x_mwdata", o_MWData, i_DWData);
        end
        check_val("x_ivalid", {31'd0, o_IValid}, {31'd0, exp_iv});
        check_val("x_dvalid", {31'd0, o_DValid}, {31'd0, exp_dv});
        check_val("x_stallf", {31'd0, o_Stall_Fetch}, {31'd0, i_IReq & ~exp_iv});
        check_val("x_stallm", {31'd0, o_Stall_Memory}, {31'd0, i_DReq & ~exp_dv});
        if (exp_iv) begin
          check_val("x_irdata", o_IRData, mem_f(i_IAddr));
          n_done++;
        end
        if (exp_dv) begin
          if (i_DWe) begin
            check_val("x_drdata_keep", o_DRData, last_dread);
          end else begin
            last_dread = mem_f(i_DAddr);
            check_val("x_drdata", o_DRData, last_dread);
          end
          n_done++;
        end

        if (exp_iv) i_IReq = 1'b0;
        if (exp_dv) i_DReq = 1'b0;
        if (!i_IReq && !exp_iv && $urandom_range(3) == 0) begin
          i_IReq  = 1'b1;
          i_IAddr = 32'h1000 | ($urandom & 32'hFFC);
        end
        if (!i_DReq && !exp_dv && $urandom_range(3) == 0) begin
          i_DReq   = 1'b1;
          i_DWe    = $urandom_range(1) == 1;
          i_DAddr  = 32'h2000 | ($urandom & 32'hFFC);
          i_DWData = $urandom;
        end
        i_MReady = ($urandom_range(2) == 0);
        i_MRData = (cur != SRC_NONE) ? mem_f(o_MAddr) : $urandom;

        p_mreq = (cur != SRC_NONE);
        p_mrdy = i_MReady;
        p_ival = exp_iv;
        p_dval = exp_dv;
        p_ireq = i_IReq;
        p_dreq = i_DReq;
      end
      check_val("x_progress", {31'd0, n_done >= 100}, 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/arm_mem_arbiter.md
ARM_MEM_ARBITER -- requirements
Module: arm_mem_arbiter

Interface
REQ-001 SHALL have parameter BusWidth, default 32, address/data width.
REQ-002 SHALL have i_CLK  input  1  clock; reset i_NRESET, asynchronous, active-low.
REQ-003 SHALL have i_SCLR  input  1  synchronous clear, active-high.
REQ-004 SHALL have i_IReq  input  1  fetch request, held until o_IValid.
REQ-005 SHALL have i_IAddr  input  BusWidth  fetch address.
REQ-006 SHALL have o_IValid  output  1  one-cycle fetch completion pulse; o_IRData  output  BusWidth  fetched word.
REQ-007 SHALL have i_DReq, i_DWe  input  1 each  data request, held until o_DValid; write enable.
REQ-008 SHALL have i_DAddr, i_DWData  input  BusWidth each  data address, write data.
REQ-009 SHALL have o_DValid  output  1  one-cycle data completion pulse; o_DRData  output  BusWidth  load data.
REQ-010 SHALL have o_MReq, o_MWe  output  1 each; o_MAddr, o_MWData  output  BusWidth each  memory port.
REQ-011 SHALL have i_MReady  input  1  memory accept/complete; i_MRData  input  BusWidth  memory read data.
REQ-012 SHALL have o_Stall_Fetch, o_Stall_Memory  output  1 each  pipeline stall requests.

Function
REQ-013 SHALL implement FSM states ARB_IDLE, ARB_IFETCH, ARB_DATA.
REQ-014 In ARB_IDLE, SHALL sample requests each edge: i_DReq -> ARB_DATA, else i_IReq -> ARB_IFETCH, else stay.
REQ-015 On entering a busy state, SHALL latch address, write data, write enable of the granted requester.
REQ-016 o_MReq SHALL be 1 exactly while in a busy state; o_MAddr/o_MWData/o_MWe SHALL be stable from latched values.
REQ-017 Busy state with i_MReady=1 SHALL complete: register i_MRData into o_IRData/o_DRData (reads only), pulse the matching o_xValid for one cycle next cycle.
REQ-018 Writes SHALL pulse o_DValid and leave o_DRData unchanged.
REQ-019 On completion, if the other requester is pending, SHALL move directly to its busy state (no idle bubble); else ARB_IDLE.
REQ-020 Minimum latency SHALL be 2 cycles: request sampled edge N, o_MReq from N, i_MReady at N, valid after edge N+1.
REQ-021 o_Stall_Fetch SHALL equal i_IReq & ~o_IValid; o_Stall_Memory SHALL equal i_DReq & ~o_DValid (combinational).
REQ-022 A requester SHALL NOT be re-granted in the cycle its o_xValid is high (request drop is assumed that cycle).
REQ-023 i_SCLR in ARB_IDLE SHALL keep ARB_IDLE and clear o_xValid.
REQ-024 i_SCLR during a busy state SHALL hold o_MReq until i_MReady, suppress the valid pulse, then go ARB_IDLE.
REQ-025 i_MReady outside busy states SHALL be ignored.

Reset
REQ-026 i_NRESET low SHALL force ARB_IDLE, all outputs 0, latched registers 0, last-grant = fetch.
REQ-027 Reset mid-transaction SHALL abandon it; no valid pulse after release.

Configuration
REQ-028 With ARM_ARB_ROUND_ROBIN_EN defined, simultaneous requests in ARB_IDLE SHALL grant the requester not served last.
REQ-029 Without ARM_ARB_ROUND_ROBIN_EN, data SHALL always win; last-grant register SHALL be omitted.

Structure
REQ-030 Package arm_pipeline_pkg SHALL hold arb_state_t enum and arb_req_t {ARB_REQ_I, ARB_REQ_D}.
REQ-031 Grant selection SHALL be sub-module arm_arb_pick (combinational; inputs IReq, DReq, last-grant; output arb_req_t).

Verification
REQ-032 Read fetch: i_IReq, i_IAddr=0x100, i_MReady=1 first busy cycle, i_MRData=0xE3A00001 -> o_MAddr=0x100, o_IValid pulse next cycle, o_IRData=0xE3A00001.
REQ-033 Simultaneous: i_IReq+i_DReq (load 0x200) -> data served first, fetch follows with no idle cycle; o_Stall_Fetch high throughout.
REQ-034 Store with 3 wait states: i_DWe=1, i_DAddr=0x40, i_DWData=0xDEADBEEF, i_MReady after 3 cycles -> o_MWe/o_MAddr/o_MWData stable 4 cycles, o_DValid pulse, o_DRData unchanged.
REQ-035 i_SCLR during ARB_DATA with pending ready -> o_MReq held until i_MReady, no o_DValid, ARB_IDLE.
REQ-036 ARM_ARB_ROUND_ROBIN_EN: continuous IReq+DReq for 4 transactions -> grants alternate D,I,D,I; without macro, D,D,D,D.
REQ-037 i_NRESET low mid-ARB_IFETCH -> all outputs 0 immediately; no o_IValid after release.
